// File: rtl/regfile_writeback_queue_if.sv
// Bundle between the write-back queue and its neighbours: the ALU and cache
// result inputs, the register_file write port, and the decode hazard query.
interface regfile_writeback_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_result;

  logic                  ld_valid;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  logic                  we3;
  logic [ADDR_WIDTH-1:0] a3;
  logic [DATA_WIDTH-1:0] wd3;

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  hazard1;
  logic                  hazard2;

  logic [CNT_W-1:0]      pending_cnt;

  // Producer side: ALU, cache and decode drive requests and observe the port.
  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_data,
    output rs1, rs2,
    input  ld_ready, we3, a3, wd3, hazard1, hazard2, pending_cnt
  );

  // The write-back queue itself.
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_data,
    input  rs1, rs2,
    output ld_ready, we3, a3, wd3, hazard1, hazard2, pending_cnt
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Write-back stage feeding the register_file write port (we3/a3/wd3).
// ALU results own the port; cache load returns go straight through when the
// port is free and nothing is queued, otherwise they wait in a small FIFO.
// A younger ALU write to the same register kills queued loads in place
// (slot stays occupied, its pop is a bubble). Decode queries pending
// destinations through rs1/rs2 -> hazard1/hazard2.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FIFO storage: per-slot valid (cleared by kill or pop), destination, data
  logic [DEPTH-1:0]      ent_vld_q, ent_vld_d;
  logic [ADDR_WIDTH-1:0] ent_rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_d [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Registered write port
  logic                  we3_q, we3_d;
  logic [ADDR_WIDTH-1:0] a3_q, a3_d;
  logic [DATA_WIDTH-1:0] wd3_q, wd3_d;

  // Per-cycle decisions
  logic alu_win;
  logic ld_nz;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic direct;
  logic ld_waw;
  logic push;

  logic hit1;
  logic hit2;

  // Arbitration: ALU first, then queued loads, then a fresh load directly
  always_comb begin
    alu_win    = bus.alu_valid && (bus.alu_rd != '0);
    ld_nz      = bus.ld_valid && (bus.ld_rd != '0);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == FULL_CNT);
    pop        = !alu_win && !fifo_empty;
    direct     = !alu_win && fifo_empty && ld_nz;
    // A load colliding with a same-cycle ALU write to the same register is
    // already stale; dropping it preserves write-after-write order.
    ld_waw     = alu_win && (bus.alu_rd == bus.ld_rd);
    // Full blocks the push even if a pop frees a slot this same cycle.
    push       = ld_nz && !fifo_full && !direct && !ld_waw;
  end

  // Next write-port value; a3/wd3 hold when nothing is selected
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (alu_win) begin
      we3_d = 1'b1;
      a3_d  = bus.alu_rd;
      wd3_d = bus.alu_result;
    end else if (!fifo_empty) begin
      // A killed head still pops, but as a bubble (valid already cleared).
      we3_d = ent_vld_q[rd_ptr_q];
      a3_d  = ent_rd_q[rd_ptr_q];
      wd3_d = ent_data_q[rd_ptr_q];
    end else if (ld_nz) begin
      we3_d = 1'b1;
      a3_d  = bus.ld_rd;
      wd3_d = bus.ld_data;
    end
  end

  // FIFO update: kill on ALU match, pop at head, push at tail
  always_comb begin
    ent_vld_d  = ent_vld_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    if (alu_win) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_rd_q[i] == bus.alu_rd) begin
          ent_vld_d[i] = 1'b0;
        end
      end
    end

    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PTR_W'(1);
    end

    // Push never targets the head slot being popped: that would need the
    // FIFO to be full, and full blocks the push.
    if (push) begin
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_rd_d[wr_ptr_q]   = bus.ld_rd;
      ent_data_d[wr_ptr_q] = bus.ld_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // RAW query: a live queued load, or the write landing at this very edge
  // (register_file reads are asynchronous and still return the old value)
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && (ent_rd_q[i] == bus.rs1)) hit1 = 1'b1;
      if (ent_vld_q[i] && (ent_rd_q[i] == bus.rs2)) hit2 = 1'b1;
    end
    bus.hazard1 = (bus.rs1 != '0) && (hit1 || (we3_q && (a3_q == bus.rs1)));
    bus.hazard2 = (bus.rs2 != '0) && (hit2 || (we3_q && (a3_q == bus.rs2)));
  end

  // Control state and write port, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      we3_q     <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      ent_vld_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      ent_vld_q <= ent_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Entry payload; meaningless unless the slot is occupied, so no reset
  always_ff @(posedge clk) begin
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

  assign bus.we3         = we3_q;
  assign bus.a3          = a3_q;
  assign bus.wd3         = wd3_q;
  assign bus.ld_ready    = !fifo_full;
  assign bus.pending_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with a write scoreboard:
// ALU and load writes are queued when driven and consumed when we3 fires.
module tb_regfile_writeback_queue;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  wr_t  alu_exp[$];
  wr_t  ld_exp[$];

  regfile_writeback_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) bus ();

  regfile_writeback_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; returns 1ns after the edge with inputs idled and
  // the resulting write (if any) checked against the scoreboard.
  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldat);
    logic alu_took;
    wr_t  e;
    alu_took       = av && (ar != 5'd0) && !rst;
    bus.alu_valid  = av;
    bus.alu_rd     = ar;
    bus.alu_result = ad;
    bus.ld_valid   = lv;
    bus.ld_rd      = lr;
    bus.ld_data    = ldat;
    if (alu_took) begin
      for (int i = ld_exp.size() - 1; i >= 0; i--)
        if (ld_exp[i].rd == ar) ld_exp.delete(i);
      alu_exp.push_back('{rd: ar, data: ad});
    end
    if (!rst && lv && (lr != 5'd0) && !(alu_took && (ar == lr)))
      ld_exp.push_back('{rd: lr, data: ldat});
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    if (rst) begin
      alu_exp.delete();
      ld_exp.delete();
    end else if (alu_took) begin
      e = alu_exp.pop_front();
      chk("alu_we3", bus.we3, 1'b1);
      chk("alu_a3", bus.a3, e.rd);
      chk("alu_wd3", bus.wd3, e.data);
    end else if (bus.we3 === 1'b1) begin
      chk("ld_write_expected", ld_exp.size() != 0, 1'b1);
      if (ld_exp.size() != 0) begin
        e = ld_exp.pop_front();
        chk("ld_a3", bus.a3, e.rd);
        chk("ld_wd3", bus.wd3, e.data);
      end
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_result = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_data    = '0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we3", bus.we3, 1'b0);
    chk("rst_a3", bus.a3, 5'd0);
    chk("rst_wd3", bus.wd3, 32'd0);
    chk("rst_cnt", bus.pending_cnt, 3'd0);
    chk("rst_ld_ready", bus.ld_ready, 1'b1);
    rst = 1'b0;

    // 1: direct load pass, one-cycle latency
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5A5A5);
    chk("t1_we3", bus.we3, 1'b1);
    chk("t1_a3", bus.a3, 5'd5);
    chk("t1_wd3", bus.wd3, 32'hA5A5A5A5);
    chk("t1_cnt", bus.pending_cnt, 3'd0);
    bus.rs1 = 5'd5;
    #1;
    chk("t1_hazard_we3_term", bus.hazard1, 1'b1);

    // 2: ALU and load collide on the port
    drive(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
    chk("t2_a3_first", bus.a3, 5'd3);
    chk("t2_cnt1", bus.pending_cnt, 3'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t2_a3_second", bus.a3, 5'd7);
    chk("t2_cnt0", bus.pending_cnt, 3'd0);

    // 3: fill the FIFO behind ALU traffic, then drain in order
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_before_push", bus.ld_ready, 1'b1);
      drive(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(16 + i), 32'h200 + i);
    end
    chk("t3_full_cnt", bus.pending_cnt, 3'd4);
    chk("t3_full_ready", bus.ld_ready, 1'b0);
    drive(1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'd0);
    chk("t3_still_full", bus.pending_cnt, 3'd4);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t3_first_pop_rd", bus.a3, 5'd16);
    chk("t3_cnt3", bus.pending_cnt, 3'd3);
    chk("t3_ready_again", bus.ld_ready, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h204);
    chk("t3_push_pop_cnt", bus.pending_cnt, 3'd3);
    repeat (3) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t3_drained_cnt", bus.pending_cnt, 3'd0);
    chk("t3_last_rd", bus.a3, 5'd20);
    chk("t3_sb_empty", ld_exp.size(), 0);

    // 4: queued load killed by a younger ALU write to the same register
    drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd9, 32'h99);
    bus.rs1 = 5'd9;
    bus.rs2 = 5'd12;
    #1;
    chk("t4_hazard1_queued", bus.hazard1, 1'b1);
    chk("t4_hazard2_we3", bus.hazard2, 1'b1);
    drive(1'b1, 5'd9, 32'h33, 1'b0, 5'd0, 32'd0);
    chk("t4_r9_data", bus.wd3, 32'h33);
    chk("t4_killed_still_counted", bus.pending_cnt, 3'd1);
    chk("t4_hazard1_during_write", bus.hazard1, 1'b1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t4_killed_pop_we3", bus.we3, 1'b0);
    chk("t4_cnt0", bus.pending_cnt, 3'd0);
    chk("t4_hazard1_cleared", bus.hazard1, 1'b0);

    // Same-cycle ALU and load to one register: load dropped
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h77);
    chk("waw_cnt", bus.pending_cnt, 3'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("waw_no_late_write", bus.we3, 1'b0);

    // 5: x0 destinations are never written or queued
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    chk("t5_alu_x0_we3", bus.we3, 1'b0);
    chk("t5_alu_x0_cnt", bus.pending_cnt, 3'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
    chk("t5_ld_x0_we3", bus.we3, 1'b0);
    chk("t5_ld_x0_cnt", bus.pending_cnt, 3'd0);
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd4, 32'h44);
    chk("t5_ld_passes_x0_alu", bus.a3, 5'd4);
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd4;
    #1;
    chk("t5_rs1_x0_no_hazard", bus.hazard1, 1'b0);
    chk("t5_rs2_hazard", bus.hazard2, 1'b1);

    // 6: reset with entries queued
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'hA21);
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd22, 32'hA22);
    drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd23, 32'hA23);
    chk("t6_cnt3", bus.pending_cnt, 3'd3);
    bus.rs1 = 5'd21;
    bus.rs2 = 5'd22;
    #1;
    chk("t6_hazard1_pre", bus.hazard1, 1'b1);
    chk("t6_hazard2_pre", bus.hazard2, 1'b1);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_rst_we3", bus.we3, 1'b0);
    chk("t6_rst_cnt", bus.pending_cnt, 3'd0);
    chk("t6_rst_ready", bus.ld_ready, 1'b1);
    chk("t6_rst_hazard1", bus.hazard1, 1'b0);
    chk("t6_rst_hazard2", bus.hazard2, 1'b0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("t6_post_rst_we3", bus.we3, 1'b0);
    chk("t6_post_rst_cnt", bus.pending_cnt, 3'd0);

    chk("final_alu_sb_empty", alu_exp.size(), 0);
    chk("final_ld_sb_empty", ld_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
